// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a six-digit seven-segment display.
//
// A snapshot of the six digit patterns is taken at the start of every frame.
// Each digit is then driven for ON_CYC cycles, followed by BLANK_CYC dark
// cycles. The digit's value cannot change partway through a frame, because the
// display shows the snapshot and not the live inputs.
//
// Handshake: there is none. en is a plain level. While en is high, frames run
// back to back. Any edge with en low returns the block to IDLE with the display
// dark.
//
// Ports:
//   inclk       clock, all state updates on the rising edge
//   rst         synchronous active-high reset, overrides en
//   en          scan enable (level)
//   sec_seg1 .. hour_seg10   7-bit digit patterns, 1 = lit, bit6..0 = g..a
//   seg_out     registered shared segment bus (inverted when SEG_ACT_LOW=1)
//   dig_sel     registered one-hot digit enable, bit0 = sec_seg1 .. bit5 = hour_seg10
//   frame_done  one-cycle pulse with the first digit of every frame after the first
module seg_scan_mux #(
    parameter int ON_CYC      = 8,
    parameter int BLANK_CYC   = 2,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] sec_seg1,
    input  logic [6:0] sec_seg10,
    input  logic [6:0] min_seg1,
    input  logic [6:0] min_seg10,
    input  logic [6:0] hour_seg1,
    input  logic [6:0] hour_seg10,
    output logic [6:0] seg_out,
    output logic [5:0] dig_sel,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [6:0] SEG_MASK   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_OFF    = SEG_MASK;
    localparam logic [7:0] ON_LAST    = 8'(ON_CYC - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

    state_t          state_q, state_n;
    logic [2:0]      idx_q, idx_n;
    logic [7:0]      cnt_q, cnt_n;
    logic [5:0][6:0] snap_q, snap_n;
    logic [5:0][6:0] din;
    logic            adv;
    logic            wrap_n;
    logic [6:0]      seg_n;
    logic [5:0]      dig_n;

    // Element 0 is sec_seg1, so the digit index matches the dig_sel bit position.
    assign din = {hour_seg10, hour_seg1, min_seg10, min_seg1, sec_seg10, sec_seg1};

    function automatic logic [6:0] pick(input logic [5:0][6:0] s, input logic [2:0] i);
        logic [6:0] r;
        r = 7'h00;
        case (i)
            3'd0:    r = s[0];
            3'd1:    r = s[1];
            3'd2:    r = s[2];
            3'd3:    r = s[3];
            3'd4:    r = s[4];
            3'd5:    r = s[5];
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        snap_n  = snap_q;
        adv     = 1'b0;
        wrap_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_n = ON;
                    idx_n   = 3'd0;
                    cnt_n   = 8'd0;
                    snap_n  = din;
                end
            end
            ON: begin
                if (!en) begin
                    state_n = IDLE;
                    idx_n   = 3'd0;
                    cnt_n   = 8'd0;
                end else if (cnt_q == ON_LAST) begin
                    cnt_n = 8'd0;
                    // With no dark gap the next digit follows immediately.
                    if (BLANK_CYC == 0) adv = 1'b1;
                    else                state_n = BLANK;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_n = IDLE;
                    idx_n   = 3'd0;
                    cnt_n   = 8'd0;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_n = 8'd0;
                    adv   = 1'b1;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 3'd0;
                cnt_n   = 8'd0;
            end
        endcase

        // Move to the next digit. After the last digit, start a new frame from a fresh snapshot.
        if (adv) begin
            state_n = ON;
            if (idx_q == 3'd5) begin
                idx_n  = 3'd0;
                snap_n = din;
                wrap_n = 1'b1;
            end else begin
                idx_n = idx_q + 3'd1;
            end
        end

        // The outputs are derived from the next state and registered with it,
        // so they line up exactly with the state that follows the clock edge.
        if (state_n == ON) begin
            dig_n = 6'b000001 << idx_n;
            seg_n = pick(snap_n, idx_n) ^ SEG_MASK;
        end else begin
            dig_n = 6'b000000;
            seg_n = SEG_OFF;
        end
    end

    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            snap_q     <= '0;
            dig_sel    <= 6'b000000;
            seg_out    <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            cnt_q      <= cnt_n;
            snap_q     <= snap_n;
            dig_sel    <= dig_n;
            seg_out    <= seg_n;
            frame_done <= wrap_n;
        end
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter ON_CYC, default 8, clock cycles a digit is driven per slot (legal range 1..255).
REQ-002 Parameter BLANK_CYC, default 2, clock cycles of dark gap after each digit (legal range 0..255).
REQ-003 Parameter SEG_ACT_LOW, default 0; 1 inverts seg_out so a lit segment drives 0.
REQ-004 inclk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  scan enable; level-sensitive.
REQ-007 sec_seg1, sec_seg10, min_seg1, min_seg10, hour_seg1, hour_seg10  input  7 each  digit segment patterns, bit=1 means segment lit, bit6..0 = g..a.
REQ-008 seg_out  output  7  shared segment bus to the display.
REQ-009 dig_sel  output  6  one-hot digit enable, active-high; bit0=sec_seg1 ... bit5=hour_seg10, in port-list order.
REQ-010 frame_done  output  1  one-cycle pulse marking the start of each new frame after the first.

Function
REQ-011 All outputs are registered; no combinational path from any input to any output.
REQ-012 "Off" SHALL mean seg_out=7'h00 when SEG_ACT_LOW=0, 7'h7F when SEG_ACT_LOW=1.
REQ-013 FSM states: IDLE, ON, BLANK; internal 3-bit digit index idx (0..5) and 8-bit slot counter cnt.
REQ-014 IDLE: dig_sel=0, seg_out=off; on an edge with en=1, capture all six inputs into a snapshot register, set idx=0, cnt=0, go ON.
REQ-015 ON: dig_sel=one-hot(idx), seg_out=snap[idx] (inverted if SEG_ACT_LOW); held exactly ON_CYC cycles.
REQ-016 After ON_CYC cycles in ON: go BLANK with dig_sel=0, seg_out=off; if BLANK_CYC=0, skip BLANK and advance directly as in REQ-017.
REQ-017 After BLANK_CYC cycles in BLANK: if idx<5, idx=idx+1, go ON; if idx=5, idx wraps to 0, recapture snapshot, go ON, and assert frame_done for that one cycle.
REQ-018 Frame period SHALL be exactly 6*(ON_CYC+BLANK_CYC) cycles; no idle cycles between frames while en=1.
REQ-019 dig_sel SHALL never have more than one bit set; dig_sel and a lit seg_out never change on the same edge as a digit switch without an intervening BLANK slot when BLANK_CYC>0.
REQ-020 Input changes mid-frame SHALL NOT affect seg_out until the next snapshot capture (tear-free frames).
REQ-021 en=0 sampled in ON or BLANK: next edge go IDLE, outputs off, frame_done=0; partial frame abandoned, no frame_done.
REQ-022 Re-enable from IDLE always restarts at idx=0 with a fresh snapshot; the first frame after IDLE produces no frame_done at its start.
REQ-023 en deasserted and reasserted on consecutive cycles: one IDLE cycle occurs, then restart per REQ-014.

Reset
REQ-024 rst=1 sampled on an edge: state=IDLE, idx=0, cnt=0, snapshot=0, dig_sel=0, seg_out=off, frame_done=0; rst overrides en.
REQ-025 rst asserted mid-frame aborts immediately on that edge; scanning resumes per REQ-014 on the first edge with rst=0 and en=1.

Verification
REQ-026 Defaults, rst high 3 cycles then low, en=1, sec_seg1=7'h06 -> edge after release dig_sel=6'b000001, seg_out=7'h06 for 8 cycles, then dig_sel=0, seg_out=0 for 2 cycles, then dig_sel=6'b000010.
REQ-027 Defaults, en=1 for 130 cycles -> frame_done pulses exactly twice, 60 cycles apart, each coinciding with dig_sel=6'b000001; dig_sel popcount <=1 every cycle.
REQ-028 Change min_seg10 from 7'h3F to 7'h5B while idx=1 -> digit 3 shows 7'h3F this frame, 7'h5B next frame.
REQ-029 en=0 while idx=4 in ON -> next edge dig_sel=0, seg_out=off, no frame_done; en=1 later -> dig_sel=6'b000001 with current inputs.
REQ-030 SEG_ACT_LOW=1, BLANK_CYC=0, all inputs 7'h7F -> seg_out=7'h00 continuously during scan, digits advance every 8 cycles with no dark cycle, 7'h7F during reset.
REQ-031 rst pulsed 1 cycle mid-BLANK of idx=2 -> next edge all outputs reset values, following edge restart at idx=0.
